// File: rtl/run_detect_sched.sv
// run_detect_sched: one run-length detector time-shared by NCH serial channels.
// A round-robin arbiter grants one requesting channel per cycle. Each channel
// keeps its own context (last bit, run count), so every channel behaves as if
// it had a private detector. A registered, channel-tagged result reports
// whether the granted channel's run has reached RUN_LEN equal bits.
// A one-cycle clr pulse starts a sweep that clears one context per cycle.
// Optional feature: define RDS_HIT_STICKY_EN to build sticky per-channel hit
// flags; without it, hit is tied to zero.
module run_detect_sched #(
  parameter int NCH     = 4,
  parameter int RUN_LEN = 4,
  parameter int CW      = 3,
  parameter int IW      = 2
) (
  input  logic           clk,
  input  logic           aclr,
  input  logic           en,
  input  logic           clr,
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] w,
  output logic [NCH-1:0] ack,
  output logic           busy,
  output logic           z_valid,
  output logic           z,
  output logic [IW-1:0]  z_ch,
  output logic [NCH-1:0] hit
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_SWEEP = 2'd2
  } state_t;

  state_t         r_state;
  logic           r_busy;
  logic [IW-1:0]  r_rr_ptr;
  logic [IW-1:0]  r_sidx;
  logic [CW-1:0]  r_cnt [NCH];
  logic [NCH-1:0] r_last;
  logic           r_z_valid;
  logic           r_z;
  logic [IW-1:0]  r_z_ch;

  logic           w_grant;
  logic [IW-1:0]  w_gidx;
  logic [NCH-1:0] w_ack;
  logic [IW:0]    w_sum;
  logic [IW-1:0]  w_idx;
  logic           w_bit;
  logic [CW-1:0]  w_new_cnt;
  logic           w_run_hit;
  logic [IW-1:0]  w_next_ptr;

  // Round-robin search from r_rr_ptr upward, wrapping modulo NCH.
  // NOTE: every signal gets a default at the top so no path leaves one unassigned (no latch).
  always_comb begin
    w_grant = 1'b0;
    w_gidx  = '0;
    w_ack   = '0;
    w_sum   = '0;
    w_idx   = '0;
    if (r_state == ST_RUN && en && !clr) begin
      for (int k = 0; k < NCH; k++) begin
        w_sum = {1'b0, r_rr_ptr} + (IW+1)'(k);
        if (w_sum >= (IW+1)'(NCH)) w_sum = w_sum - (IW+1)'(NCH);
        w_idx = w_sum[IW-1:0];
        if (!w_grant && req[w_idx]) begin
          w_grant = 1'b1;
          w_gidx  = w_idx;
        end
      end
    end
    if (w_grant) w_ack[w_gidx] = 1'b1;
  end

  // Next run count for the granted channel: restart on a new bit, else count up saturating.
  always_comb begin
    w_bit = w[w_gidx];
    if (r_cnt[w_gidx] == '0 || w_bit != r_last[w_gidx]) begin
      w_new_cnt = CW'(1);
    end else if (r_cnt[w_gidx] >= CW'(RUN_LEN)) begin
      w_new_cnt = CW'(RUN_LEN);
    end else begin
      w_new_cnt = r_cnt[w_gidx] + CW'(1);
    end
    w_run_hit  = (w_new_cnt == CW'(RUN_LEN));
    w_next_ptr = (w_gidx == IW'(NCH-1)) ? '0 : w_gidx + IW'(1);
  end

  // Control FSM: idle/run/sweep sequencing, sweep index, busy flag and round-robin pointer.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_state  <= ST_IDLE;
      r_busy   <= 1'b0;
      r_sidx   <= '0;
      r_rr_ptr <= '0;
    end else begin
      if (w_grant) r_rr_ptr <= w_next_ptr;
      case (r_state)
        ST_IDLE: begin
          if (clr) begin
            r_state <= ST_SWEEP;
            r_busy  <= 1'b1;
            r_sidx  <= '0;
          end else if (en) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (clr) begin
            r_state <= ST_SWEEP;
            r_busy  <= 1'b1;
            r_sidx  <= '0;
          end else if (!en) begin
            r_state <= ST_IDLE;
          end
        end
        ST_SWEEP: begin
          if (r_sidx == IW'(NCH-1)) begin
            r_state <= en ? ST_RUN : ST_IDLE;
            r_busy  <= 1'b0;
            r_sidx  <= '0;
          end else begin
            r_sidx <= r_sidx + IW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Per-channel contexts: cleared one per cycle by the sweep, updated on a grant.
  // NOTE: the context array is reset explicitly because every channel must start with an empty run.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
      r_last <= '0;
    end else if (r_state == ST_SWEEP) begin
      r_cnt[r_sidx]  <= '0;
      r_last[r_sidx] <= 1'b0;
    end else if (w_grant) begin
      r_cnt[w_gidx]  <= w_new_cnt;
      r_last[w_gidx] <= w_bit;
    end
  end

  // Tagged result one cycle after the grant; z and z_ch hold when nothing was granted.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_z_valid <= 1'b0;
      r_z       <= 1'b0;
      r_z_ch    <= '0;
    end else if (w_grant) begin
      r_z_valid <= 1'b1;
      r_z       <= w_run_hit;
      r_z_ch    <= w_gidx;
    end else begin
      r_z_valid <= 1'b0;
    end
  end

`ifdef RDS_HIT_STICKY_EN
  logic [NCH-1:0] r_hit;

  // Sticky run flags: set on a z=1 result, cleared only by reset or the channel's sweep step.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_hit <= '0;
    end else if (r_state == ST_SWEEP) begin
      r_hit[r_sidx] <= 1'b0;
    end else if (w_grant && w_run_hit) begin
      r_hit[w_gidx] <= 1'b1;
    end
  end

  assign hit = r_hit;
`else
  assign hit = '0;
`endif

  assign ack     = w_ack;
  assign busy    = r_busy;
  assign z_valid = r_z_valid;
  assign z       = r_z;
  assign z_ch    = r_z_ch;

endmodule

// File: tb/tb_run_detect_sched.sv
// Self-checking bench for run_detect_sched: a behavioural model predicts ack and
// the registered outputs every cycle; directed scenarios add literal expectations.
module tb_run_detect_sched;

  localparam int NCH     = 4;
  localparam int RUN_LEN = 4;
  localparam int CW      = 3;
  localparam int IW      = 2;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_SWEEP = 2;

  logic           clk;
  logic           aclr;
  logic           en;
  logic           clr;
  logic [NCH-1:0] req;
  logic [NCH-1:0] w;
  logic [NCH-1:0] ack;
  logic           busy;
  logic           z_valid;
  logic           z;
  logic [IW-1:0]  z_ch;
  logic [NCH-1:0] hit;

  int n_tests = 0;
  int n_fail  = 0;

  // Results and grants seen by the compare process, for the directed checks.
  int             res_ch [$];
  int             res_z  [$];
  logic [NCH-1:0] ack_log [$];

  // Values sampled on the falling edge by cyc().
  logic [NCH-1:0] s_ack;
  logic           s_busy;
  logic           s_zv;
  logic [NCH-1:0] s_hit;

  run_detect_sched #(
    .NCH(NCH), .RUN_LEN(RUN_LEN), .CW(CW), .IW(IW)
  ) dut (
    .clk(clk), .aclr(aclr), .en(en), .clr(clr), .req(req), .w(w),
    .ack(ack), .busy(busy), .z_valid(z_valid), .z(z), .z_ch(z_ch), .hit(hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: sample on the falling edge, return just after the rising edge.
  task automatic cyc();
    @(negedge clk);
    s_ack  = ack;
    s_busy = busy;
    s_zv   = z_valid;
    s_hit  = hit;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    aclr = 1'b0;
    en   = 1'b0;
    clr  = 1'b0;
    req  = '0;
    w    = '0;
    cyc();
    cyc();
    aclr = 1'b1;
    res_ch.delete();
    res_z.delete();
    ack_log.delete();
  endtask

  // ---------------- behavioural model + compare process ----------------
  int             m_mode;
  int             m_sidx;
  int             m_rr;
  int             m_cnt  [NCH];
  int             m_last [NCH];
  int             m_hit  [NCH];
  int             m_zv;
  int             m_z;
  int             m_zch;
  int             g;
  int             c;
  int             b;
  logic [NCH-1:0] exp_ack;
  logic [NCH-1:0] exp_hit;

  initial begin
    forever begin
      @(negedge clk);
      if (!aclr) begin
        m_mode = M_IDLE; m_sidx = 0; m_rr = 0;
        m_zv = 0; m_z = 0; m_zch = 0;
        for (int i = 0; i < NCH; i++) begin
          m_cnt[i] = 0; m_last[i] = 0; m_hit[i] = 0;
        end
        check("rst_ack", 32'(ack), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_zv", 32'(z_valid), 0);
        check("rst_z", 32'(z), 0);
        check("rst_zch", 32'(z_ch), 0);
        check("rst_hit", 32'(hit), 0);
      end else begin
        // Registered outputs against the model's state after the last edge.
        exp_hit = '0;
`ifdef RDS_HIT_STICKY_EN
        for (int i = 0; i < NCH; i++) exp_hit[i] = (m_hit[i] != 0);
`endif
        check("busy", 32'(busy), 32'(m_mode == M_SWEEP));
        check("z_valid", 32'(z_valid), 32'(m_zv));
        check("z", 32'(z), 32'(m_z));
        check("z_ch", 32'(z_ch), 32'(m_zch));
        check("hit", 32'(hit), 32'(exp_hit));
        if (z_valid) begin
          res_ch.push_back(int'(z_ch));
          res_z.push_back(int'(z));
        end

        // Grant the first requester at or after the pointer.
        g = -1;
        if (m_mode == M_RUN && en && !clr) begin
          for (int k = 0; k < NCH; k++) begin
            c = (m_rr + k) % NCH;
            if (g < 0 && req[c]) g = c;
          end
        end
        exp_ack = '0;
        if (g >= 0) exp_ack[g] = 1'b1;
        check("ack", 32'(ack), 32'(exp_ack));
        if (ack != '0) ack_log.push_back(ack);

        // Advance the model across the coming rising edge.
        if (g >= 0) begin
          b = int'(w[g]);
          if (m_cnt[g] == 0 || b != m_last[g]) m_cnt[g] = 1;
          else if (m_cnt[g] < RUN_LEN) m_cnt[g] = m_cnt[g] + 1;
          m_last[g] = b;
          m_zv = 1;
          m_z = (m_cnt[g] == RUN_LEN) ? 1 : 0;
          m_zch = g;
          if (m_z == 1) m_hit[g] = 1;
          m_rr = (g + 1) % NCH;
        end else begin
          m_zv = 0;
        end
        if (m_mode == M_SWEEP) begin
          m_cnt[m_sidx] = 0;
          m_last[m_sidx] = 0;
          m_hit[m_sidx] = 0;
          if (m_sidx == NCH - 1) m_mode = en ? M_RUN : M_IDLE;
          else m_sidx = m_sidx + 1;
        end else if (clr) begin
          m_mode = M_SWEEP;
          m_sidx = 0;
        end else if (m_mode == M_IDLE && en) begin
          m_mode = M_RUN;
        end else if (m_mode == M_RUN && !en) begin
          m_mode = M_IDLE;
        end
      end
    end
  end

  // Runaway guard.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_tests %0d", n_tests);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  int seq2 [7] = '{1, 1, 1, 0, 0, 0, 0};
  int exp2 [7] = '{0, 0, 0, 0, 0, 0, 1};
  int idx2;
  int n2;
  logic [NCH-1:0] t2_ack [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [NCH-1:0] hit_exp;

  initial begin
    s_ack = '0; s_busy = 1'b0; s_zv = 1'b0; s_hit = '0;
    do_reset();

    // T1: ch0 presents 0 four times -> z = 0,0,0,1 on channel 0.
    en = 1'b1; req = 4'b0001; w = 4'b0000;
    repeat (5) cyc();
    req = '0;
    cyc(); cyc();
    check("t1_nres", res_z.size(), 4);
    if (res_z.size() == 4) begin
      check("t1_z0", res_z[0], 0);
      check("t1_z1", res_z[1], 0);
      check("t1_z2", res_z[2], 0);
      check("t1_z3", res_z[3], 1);
      check("t1_ch3", res_ch[3], 0);
    end

    // T2: all channels request -> strict rotation from channel 0.
    do_reset();
    en = 1'b1; req = 4'b1111; w = 4'($urandom);
    repeat (9) cyc();
    req = '0;
    cyc(); cyc();
    check("t2_nack", ack_log.size(), 8);
    check("t2_nres", res_ch.size(), 8);
    if (ack_log.size() == 8 && res_ch.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check("t2_ack", 32'(ack_log[i]), 32'(t2_ack[i]));
        check("t2_zch", res_ch[i], i % 4);
      end
    end

    // T3: ch2 runs 1,1,1,0,0,0,0 while ch1 sends random bits.
    do_reset();
    en = 1'b1; req = 4'b0110; idx2 = 0;
    w = '0; w[2] = 1'(seq2[0]); w[1] = 1'($urandom);
    for (int n = 0; n < 40 && idx2 < 7; n++) begin
      cyc();
      if (s_ack[1]) w[1] = 1'($urandom);
      if (s_ack[2]) begin
        idx2++;
        if (idx2 < 7) w[2] = 1'(seq2[idx2]);
        else req[2] = 1'b0;
      end
    end
    check("t3_done", idx2, 7);
    req = '0;
    cyc(); cyc();
    n2 = 0;
    foreach (res_ch[i]) begin
      if (res_ch[i] == 2) begin
        if (n2 < 7) check("t3_ch2_z", res_z[i], exp2[n2]);
        n2++;
      end
    end
    check("t3_ch2_nres", n2, 7);

    // T4: ch0 at cnt=3, clear sweep, then w=1 restarts the run.
    do_reset();
    en = 1'b1; req = 4'b0001; w = 4'b0001;
    repeat (4) cyc();
    clr = 1'b1;
    cyc();
    check("t4_clr_ack", 32'(s_ack), 0);
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("t4_busy", 32'(s_busy), 1);
      check("t4_ack", 32'(s_ack), 0);
    end
    res_z.delete();
    res_ch.delete();
    cyc();
    check("t4_busy_end", 32'(s_busy), 0);
    check("t4_ack_end", 32'(s_ack), 32'(4'b0001));
    req = '0;
    cyc();
    check("t4_nres", res_z.size(), 1);
    if (res_z.size() == 1) check("t4_z", res_z[0], 0);

    // T5: ch3 sees 1,1, pauses with en=0, then 1,1 -> second one raises z.
    do_reset();
    en = 1'b1; req = 4'b1000; w = 4'b1000;
    repeat (3) cyc();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("t5_ack_off", 32'(s_ack), 0);
      if (i > 0) check("t5_zv_off", 32'(s_zv), 0);
    end
    en = 1'b1;
    res_z.delete();
    res_ch.delete();
    repeat (3) cyc();
    req = '0;
    cyc(); cyc();
    check("t5_nres", res_z.size(), 2);
    if (res_z.size() == 2) begin
      check("t5_z0", res_z[0], 0);
      check("t5_z1", res_z[1], 1);
    end

    // T6: ch1 hits its run, then differs; aclr in the middle of a sweep.
`ifdef RDS_HIT_STICKY_EN
    hit_exp = 4'b0010;
`else
    hit_exp = 4'b0000;
`endif
    do_reset();
    en = 1'b1; req = 4'b0010; w = 4'b0010;
    repeat (5) cyc();
    w = 4'b0000;
    cyc();
    check("t6_hit_set", 32'(s_hit), 32'(hit_exp));
    cyc(); cyc();
    check("t6_hit_keep", 32'(s_hit), 32'(hit_exp));
    req = '0;
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    cyc();
    check("t6_mid_busy", 32'(busy), 1);
    aclr = 1'b0;
    #1;
    check("t6_ack", 32'(ack), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_zv", 32'(z_valid), 0);
    check("t6_z", 32'(z), 0);
    check("t6_zch", 32'(z_ch), 0);
    check("t6_hit", 32'(hit), 0);
    cyc();
    aclr = 1'b1;
    cyc();
    check("t6_no_resume", 32'(s_busy), 0);

    // Random traffic: requesters hold their bit until acked; occasional en/clr/aclr.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      en  = ($urandom_range(0, 19) != 0);
      clr = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < NCH; i++) begin
        if (!req[i] || s_ack[i]) begin
          req[i] = ($urandom_range(0, 9) < 6);
          if ($urandom_range(0, 3) == 0) w[i] = ~w[i];
        end
      end
      aclr = ($urandom_range(0, 799) != 0);
      cyc();
    end
    aclr = 1'b1; en = 1'b0; clr = 1'b0; req = '0;
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
